// File: rtl/mod_counter_if.sv
// Control and status bundle for mod_counter.
// The master drives the control inputs; the slave (the counter) drives the registered status.
interface mod_counter_if #(
   parameter int WIDTH = 8
);
   // No valid/ready handshake: en/load/preset/limit/dir/mode are level inputs sampled on every
   // rising clk edge, and count/tcount/done/wraps/state are registered outputs for that edge.
   logic             en;
   logic             load;
   logic [WIDTH-1:0] preset;
   logic [WIDTH-1:0] limit;
   logic             dir;
   logic             mode;
   logic [WIDTH-1:0] count;
   logic             tcount;
   logic             done;
   logic [7:0]       wraps;
   logic [0:0]       state;

   modport master (
      output en, load, preset, limit, dir, mode,
      input  count, tcount, done, wraps, state
   );

   modport slave (
      input  en, load, preset, limit, dir, mode,
      output count, tcount, done, wraps, state
   );
endinterface

// File: rtl/mod_counter.sv
// Parametrised up/down modulo counter with runtime limit, periodic/one-shot mode,
// terminal-count pulse, done flag and saturating terminal-event counter.
module mod_counter #(
   parameter int WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   mod_counter_if.slave  bus
);

   localparam logic [0:0] ST_COUNT = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tcount_q, tcount_d;
   logic [7:0]       wraps_q, wraps_d;
   logic             at_term;

   // Down counting never wraps below zero, so zero is always the down terminal.
   assign at_term = bus.dir ? (count_q == bus.limit) : (count_q == '0);

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      tcount_d = 1'b0;
      wraps_d  = wraps_q;
      if (bus.load) begin
         state_d = ST_COUNT;
         count_d = bus.preset;
         wraps_d = 8'd0;
      end else if ((state_q == ST_COUNT) && bus.en) begin
         if (at_term) begin
            tcount_d = 1'b1;
            wraps_d  = (wraps_q == 8'hFF) ? wraps_q : wraps_q + 8'd1;
            if (bus.mode) begin
               state_d = ST_HOLD;
            end else begin
               count_d = bus.dir ? '0 : bus.limit;
            end
         end else begin
            count_d = bus.dir ? count_q + 1'b1 : count_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_COUNT;
         count_q  <= '0;
         tcount_q <= 1'b0;
         wraps_q  <= 8'd0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         tcount_q <= tcount_d;
         wraps_q  <= wraps_d;
      end
   end

   assign bus.count  = count_q;
   assign bus.tcount = tcount_q;
   assign bus.done   = (state_q == ST_HOLD);
   assign bus.wraps  = wraps_q;
   assign bus.state  = state_q;

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter that generalises the team's 8-bit preset counter. It adds a programmable width, a runtime terminal limit, a direction select, a count enable, and a periodic or one-shot mode. It also adds a done flag and a saturating count of terminal events. It sits beside timer and baud-tick logic as a reusable tick and period generator.

## Interface
- WIDTH, 8, counter width in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- en  input  1  count enable; no effect in HOLD
- load  input  1  synchronous load of preset; also re-arms from HOLD
- preset  input  WIDTH  load value
- limit  input  WIDTH  terminal value when counting up; reload value when counting down
- dir  input  1  1 = up, 0 = down
- mode  input  1  0 = periodic, 1 = one-shot
- count  output  WIDTH  current count (registered)
- tcount  output  1  one-cycle terminal-count pulse (registered)
- done  output  1  high while in HOLD (one-shot expired)
- wraps  output  8  number of terminal events, saturating at 255

## Operation
- Reset is synchronous and active-high: one clock and one reset, with the polarity and synchronicity fixed.
- Two states: COUNT and HOLD. Reset and load both go to COUNT.
- Priority per edge: reset > load > en > idle.
- reset: count=0, tcount=0, done=0, wraps=0, state=COUNT.
- load: count=preset, tcount=0, wraps=0, state=COUNT, done=0. A load at terminal does not produce tcount.
- COUNT, en=1, terminal condition: up with count==limit, or down with count==0.
  - tcount=1 next cycle; wraps increments unless already 255.
  - Periodic: up reloads count to 0; down reloads count to limit.
  - One-shot: count holds the terminal value; state=HOLD; done=1.
- COUNT, en=1, not terminal: count ±1 modulo 2^WIDTH.
  - Up with count>limit counts through all-ones, wraps to 0 with no tcount, then reaches limit normally.
  - Down never wraps past 0; 0 is always terminal.
- COUNT, en=0: count holds; tcount=0.
- HOLD: count holds; en is ignored; done=1; tcount=0 after the first pulse. Only load or reset exits HOLD.
- dir, mode and limit are sampled at every edge with no internal latching. A change takes effect on the next enabled edge.
- limit==0 (either direction, periodic): every enabled edge is terminal. count stays 0 and tcount stays high continuously while en=1.

## Timing
- All outputs are registered. No combinational path runs from input to output.
- Load latency is 1 cycle: count==preset in the cycle after load is sampled.
- The terminal edge updates count (reload or hold) and sets tcount on the same edge. tcount is therefore high in the cycle showing the reloaded value. done rises together with tcount in one-shot mode.
- Periodic period with en held high:
  - up: limit+1 cycles from count=0
  - down: limit+1 cycles after the first reload
- tcount width is exactly 1 cycle per terminal event, except in the limit==0 continuous case.
- A reset asserted mid-count forces all outputs to reset values one edge later, regardless of load or en.

## Test plan
- Reset for 2 cycles with en=1 and load=1 → count=0x00, tcount=0, done=0, wraps=0; reset overrides load.
- WIDTH=8, limit=9, dir=1, mode=0, en=1 from count 0 → count runs 0..9,0..; tcount high for exactly 1 cycle every 10 cycles, coincident with count=0; wraps=3 after 30 cycles.
- Load preset=0x0A, dir=0, mode=1, en=1 → count 10 down to 0; on the edge at count 0, tcount pulses once and done=1; count holds 0 for 20 further cycles. Then load preset=0x05 → done=0, count=5, counting resumes.
- count==limit=0x20 (up), with load=1 (preset=0x80) and en=1 on the same edge → count=0x80, tcount=0, wraps=0. Counting up then wraps 0xFF→0x00 with no tcount, and tcount fires when count reaches 0x20.
- Reset asserted at count=0x37 while running → next cycle count=0, tcount=0. Counting resumes from 0 one cycle after reset deasserts.
- limit=0, periodic, en=1 for 300 cycles → tcount continuously 1, count=0; wraps saturates at 255 and stays there.
